// File: rtl/vdp99_pkg.sv
// vdp99_pkg: default 640x480@60 raster timing (2x TMS scaling) and counter width for the vdp99 VGA path.
package vdp99_pkg;
  localparam int CW = 10;
  localparam int P_HVID = 512;
  localparam int P_HRB = 64;
  localparam int P_HFP = 16;
  localparam int P_HS = 96;
  localparam int P_HBP = 48;
  localparam int P_HLB = 64;
  localparam int P_HTXT = 16;
  localparam int P_VVID = 384;
  localparam int P_VBB = 48;
  localparam int P_VFP = 10;
  localparam int P_VS = 2;
  localparam int P_VBP = 33;
  localparam int P_VTB = 48;
  function automatic int span6(input int a, input int b, input int c, input int d, input int e, input int f);
    return a + b + c + d + e + f;
  endfunction
endpackage

// File: rtl/vga_counter.sv
// vga_counter: free-running modulo-N counter advancing on en, with a wrap pulse on its last step.
module vga_counter
  import vdp99_pkg::*;
#(
  parameter int N = 800
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  output logic [CW-1:0] cnt,
  output logic          wrap
);
  assign wrap = en && cnt == CW'(N - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) cnt <= '0;
    else if (en) cnt <= wrap ? '0 : cnt + CW'(1);
endmodule

// File: rtl/vgasync.sv
// vgasync: raster timing generator; decodes sync, active and border regions from the h/v counters.
module vgasync
  import vdp99_pkg::*;
#(
  parameter int HVID = P_HVID,
  parameter int HRB = P_HRB,
  parameter int HFP = P_HFP,
  parameter int HS = P_HS,
  parameter int HBP = P_HBP,
  parameter int HLB = P_HLB,
  parameter int HTXT = P_HTXT,
  parameter int VVID = P_VVID,
  parameter int VBB = P_VBB,
  parameter int VFP = P_VFP,
  parameter int VS = P_VS,
  parameter int VBP = P_VBP,
  parameter int VTB = P_VTB
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          text_mode,
  output logic          hsync,
  output logic          vsync,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic          vid_active,
  output logic          border,
  output logic [CW-1:0] px_col,
  output logic [CW-1:0] px_row,
  output logic          eol,
  output logic          eof
);
  localparam int HTOT = span6(HVID, HRB, HFP, HS, HBP, HLB);
  localparam int VTOT = span6(VVID, VBB, VFP, VS, VBP, VTB);
  localparam bit TRIM = 2 * HTXT < HVID;
  localparam logic [CW-1:0] HS0 = CW'(HVID + HRB + HFP);
  localparam logic [CW-1:0] HS1 = CW'(HVID + HRB + HFP + HS);
  localparam logic [CW-1:0] VS0 = CW'(VVID + VBB + VFP);
  localparam logic [CW-1:0] VS1 = CW'(VVID + VBB + VFP + VS);
  localparam logic [CW-1:0] HVIS = CW'(HVID + HRB);
  localparam logic [CW-1:0] HLB0 = CW'(HTOT - HLB);
  localparam logic [CW-1:0] VVIS = CW'(VVID + VBB);
  localparam logic [CW-1:0] VTB0 = CW'(VTOT - VTB);
  localparam logic [CW-1:0] HV = CW'(HVID);
  localparam logic [CW-1:0] VV = CW'(VVID);
  localparam logic [CW-1:0] TX = CW'(HTXT);
  logic [CW-1:0] t;
  logic act_col, visible;
  vga_counter #(.N(HTOT)) u_h (.clk(clk), .reset(reset), .en(1'b1), .cnt(col), .wrap(eol));
  vga_counter #(.N(VTOT)) u_v (.clk(clk), .reset(reset), .en(eol), .cnt(row), .wrap(eof));
  // Text trim only narrows the active window; line length is untouched.
  always_comb begin
    t = (TRIM && text_mode) ? TX : '0;
    act_col = col >= t && col < HV - t;
    visible = (col < HVIS || col >= HLB0) && (row < VVIS || row >= VTB0);
  end
  assign vid_active = act_col && row < VV;
  assign border = visible && !vid_active;
  assign px_col = col - t;
  assign px_row = row;
  assign hsync = !(col >= HS0 && col < HS1);
  assign vsync = !(row >= VS0 && row < VS1);
endmodule

// File: tb/tb_vgasync.sv
// tb_vgasync: random text_mode/reset stimulus vs. a pixel-index reference model, checked via scoreboard queue.
module tb_vgasync;
  localparam int HVID = 5, HRB = 2, HFP = 2, HS = 3, HBP = 4, HLB = 2;
  localparam int VVID = 3, VBB = 2, VFP = 4, VS = 2, VBP = 3, VTB = 2;
  localparam int HTOT = 18, VTOT = 16, FRAME = HTOT * VTOT;

  typedef struct {
    int col, row, hs, vs, va1, bd1, px1, va2, bd2, px2, eol, eof;
  } exp_t;

  logic clk = 0, reset = 0, text_mode = 0;
  logic hsync, vsync, vid_active, border, eol, eof;
  logic [9:0] col, row, px_col, px_row;
  logic hsync2, vsync2, vid_active2, border2, eol2, eof2;
  logic [9:0] col2, row2, px_col2, px_row2;
  int total = 0, bad = 0, p = 0;
  exp_t q[$];

  always #5 clk = ~clk;

  vgasync #(.HVID(HVID), .HRB(HRB), .HFP(HFP), .HS(HS), .HBP(HBP), .HLB(HLB), .HTXT(1),
            .VVID(VVID), .VBB(VBB), .VFP(VFP), .VS(VS), .VBP(VBP), .VTB(VTB)) dut (
    .clk(clk), .reset(reset), .text_mode(text_mode), .hsync(hsync), .vsync(vsync),
    .col(col), .row(row), .vid_active(vid_active), .border(border), .px_col(px_col),
    .px_row(px_row), .eol(eol), .eof(eof));

  vgasync #(.HVID(HVID), .HRB(HRB), .HFP(HFP), .HS(HS), .HBP(HBP), .HLB(HLB),
            .VVID(VVID), .VBB(VBB), .VFP(VFP), .VS(VS), .VBP(VBP), .VTB(VTB)) dut_def (
    .clk(clk), .reset(reset), .text_mode(text_mode), .hsync(hsync2), .vsync(vsync2),
    .col(col2), .row(row2), .vid_active(vid_active2), .border(border2), .px_col(px_col2),
    .px_row(px_row2), .eol(eol2), .eof(eof2));

  // Expected outputs from the pixel index within the frame and the trim width.
  function automatic exp_t model(input int pix, input bit tm);
    exp_t e;
    int c = pix % HTOT, r = pix / HTOT;
    int t1 = tm ? 1 : 0;
    bit vis = (c < HVID + HRB || c >= HTOT - HLB) && (r < VVID + VBB || r >= VTOT - VTB);
    e.col = c;
    e.row = r;
    e.hs = (c >= 9 && c <= 11) ? 0 : 1;
    e.vs = (r >= 9 && r <= 10) ? 0 : 1;
    e.va1 = (c >= t1 && c < HVID - t1 && r < VVID) ? 1 : 0;
    e.bd1 = (vis && !e.va1) ? 1 : 0;
    e.px1 = c - t1;
    e.va2 = (c < HVID && r < VVID) ? 1 : 0;
    e.bd2 = (vis && !e.va2) ? 1 : 0;
    e.px2 = c;
    e.eol = (c == HTOT - 1) ? 1 : 0;
    e.eof = (c == HTOT - 1 && r == VTOT - 1) ? 1 : 0;
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s at %0t: got %0d want %0d", name, $time, act, req);
    end
  endtask

  task automatic step(input logic rst_v);
    @(posedge clk);
    if (reset) p = (p + 1) % FRAME;
    #2;
    reset = rst_v;
    if (!rst_v) p = 0;
    text_mode = 1'($urandom_range(0, 1));
    q.push_back(model(p, text_mode));
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("col", 32'(col), e.col);
        chk("row", 32'(row), e.row);
        chk("px_row", 32'(px_row), e.row);
        chk("hsync", 32'(hsync), e.hs);
        chk("vsync", 32'(vsync), e.vs);
        chk("vid_active", 32'(vid_active), e.va1);
        chk("border", 32'(border), e.bd1);
        if (e.va1 != 0) chk("px_col", 32'(px_col), e.px1);
        chk("eol", 32'(eol), e.eol);
        chk("eof", 32'(eof), e.eof);
        chk("def_col", 32'(col2), e.col);
        chk("def_vid_active", 32'(vid_active2), e.va2);
        chk("def_border", 32'(border2), e.bd2);
        if (e.va2 != 0) chk("def_px_col", 32'(px_col2), e.px2);
      end
    end
  end

  initial begin
    repeat (4) step(1'b0);
    step(1'b1);
    repeat (2 * FRAME + 5 * HTOT + 8 - 1) step(1'b1);
    step(1'b0);
    repeat (2) step(1'b0);
    step(1'b1);
    repeat (FRAME + 20) step(1'b1);
    repeat (4) @(negedge clk);
    if (q.size() != 0) chk("drain", 32'(q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
